// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode pipeline buffer holding in-order {ir, pc} pairs.
// Latency: entry pushed at edge N is on out_* with out_valid in the cycle after N; 1 instr/cycle streaming.
// Backpressure: in_ready drops when full; IFID_SKID_EN gives a 2-entry queue with registered in_ready, else 1 entry with in_ready = empty | out_ready.
module if_id_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_ir,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pcwrite,
  output logic [WIDTH-1:0] out_ir,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       count
);

  logic w_in_ready;
  logic w_push;
  logic w_pop;

  // Fetch only advances its PC when the instruction is really taken; reset and flush veto it.
  assign w_push   = in_valid & w_in_ready & ~flush & rst;
  assign w_pop    = out_valid & out_ready & ~flush;
  assign pcwrite  = w_push;
  assign in_ready = w_in_ready;

`ifdef IFID_SKID_EN
  // Slot 0 is always the head; slot 1 is the skid entry behind it.
  logic [WIDTH-1:0] r_ir0;
  logic [WIDTH-1:0] r_pc0;
  logic [WIDTH-1:0] r_ir1;
  logic [WIDTH-1:0] r_pc1;
  logic [1:0]       r_count;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [1:0]       w_count_nxt;
  logic             w_to_slot0;

  // Next occupancy: flush empties, push/pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = 2'd0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // A new entry lands in the head slot if the queue is, or is about to become, empty.
  assign w_to_slot0 = (r_count == 2'd0) || ((r_count == 2'd1) && w_pop);

  // Queue storage, occupancy and the registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ir0       <= '0;
      r_pc0       <= '0;
      r_ir1       <= '0;
      r_pc1       <= '0;
      r_count     <= 2'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != 2'd0);
      r_in_ready  <= (w_count_nxt < 2'd2);
      // Popping a full queue promotes the skid entry; the head otherwise holds its last value.
      if (w_pop && (r_count == 2'd2)) begin
        r_ir0 <= r_ir1;
        r_pc0 <= r_pc1;
      end
      if (w_push) begin
        if (w_to_slot0) begin
          r_ir0 <= in_ir;
          r_pc0 <= in_pc;
        end else begin
          r_ir1 <= in_ir;
          r_pc1 <= in_pc;
        end
      end
    end
  end

  assign w_in_ready = r_in_ready;
  assign out_ir     = r_ir0;
  assign out_pc     = r_pc0;
  assign out_valid  = r_out_valid;
  assign count      = r_count;

`else
  // Single pipeline register; a consuming decode frees the slot in the same cycle.
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_pc;
  logic             r_valid;

  assign w_in_ready = ~r_valid | out_ready;

  // Entry register: flush wins, then push (covers push+pop), then pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ir    <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_push) begin
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      if (w_push) begin
        r_ir <= in_ir;
        r_pc <= in_pc;
      end
    end
  end

  assign out_ir    = r_ir;
  assign out_pc    = r_pc;
  assign out_valid = r_valid;
  assign count     = {1'b0, r_valid};
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_if_id_buffer;
`ifdef IFID_SKID_EN
  localparam int DEPTH = 2;
  localparam bit SKID  = 1'b1;
`else
  localparam int DEPTH = 1;
  localparam bit SKID  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_ir, in_pc, out_ir, out_pc;
  logic        in_valid, in_ready, pcwrite, out_valid, out_ready, flush;
  logic [1:0]  count;

  always #5 clk = ~clk;

  if_id_buffer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_ir(in_ir), .in_pc(in_pc), .in_valid(in_valid),
    .in_ready(in_ready), .pcwrite(pcwrite), .out_ir(out_ir), .out_pc(out_pc),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .count(count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-order queue plus the last head shown to decode.
  logic [15:0] q_ir[$];
  logic [15:0] q_pc[$];
  logic [15:0] m_ir = 16'h0000;
  logic [15:0] m_pc = 16'h0000;
  logic exp_in_ready, exp_pcwrite, obs_in_ready, obs_pcwrite;

  function automatic logic [1:0] m_count();
    return 2'(q_ir.size());
  endfunction

  // Drive one cycle at the falling edge, sample combinational outputs, advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [15:0] ir, input logic [15:0] pc,
                       input logic ordy, input logic fl, input logic rs);
    @(negedge clk);
    rst = rs; in_valid = v; in_ir = ir; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    obs_in_ready = in_ready;
    obs_pcwrite  = pcwrite;
    exp_in_ready = (q_ir.size() < DEPTH) || (!SKID && ordy);
    exp_pcwrite  = rs && v && exp_in_ready && !fl;
    @(posedge clk);
    if (!rs) begin
      q_ir.delete(); q_pc.delete(); m_ir = 16'h0000; m_pc = 16'h0000;
    end else if (fl) begin
      q_ir.delete(); q_pc.delete();
    end else begin
      if (q_ir.size() > 0 && ordy) begin
        void'(q_ir.pop_front()); void'(q_pc.pop_front());
      end
      if (exp_pcwrite) begin
        q_ir.push_back(ir); q_pc.push_back(pc);
      end
    end
    if (q_ir.size() > 0) begin m_ir = q_ir[0]; m_pc = q_pc[0]; end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 16'h1234, 16'h0042, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h1234, 16'h0042, 1'b0, 1'b0, 1'b0);
    checks++; if (obs_pcwrite !== 1'b0) begin errors++; $display("FAIL reset_pcwrite_during: got %b want 0", obs_pcwrite); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (out_ir !== 16'h0000) begin errors++; $display("FAIL reset_out_ir: got %h want 0000", out_ir); end
    checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL reset_out_pc: got %h want 0000", out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (pcwrite !== 1'b0) begin errors++; $display("FAIL reset_pcwrite: got %b want 0", pcwrite); end
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_single();
    cycle(1'b1, 16'hA005, 16'h0010, 1'b0, 1'b0, 1'b1);
    checks++; if (obs_pcwrite !== 1'b1) begin errors++; $display("FAIL single_pcwrite: got %b want 1", obs_pcwrite); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    checks++; if (out_ir !== 16'hA005) begin errors++; $display("FAIL single_out_ir: got %h want a005", out_ir); end
    checks++; if (out_pc !== 16'h0010) begin errors++; $display("FAIL single_out_pc: got %h want 0010", out_pc); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL single_pop_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
    checks++; if (out_ir !== 16'hA005) begin errors++; $display("FAIL single_hold_ir: got %h want a005", out_ir); end
  endtask

  task automatic test_fill();
    cycle(1'b1, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++; if (obs_pcwrite !== 1'b1) begin errors++; $display("FAIL fill_push1: got %b want 1", obs_pcwrite); end
`ifdef IFID_SKID_EN
    cycle(1'b1, 16'h2222, 16'h0001, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill_count2: got %0d want 2", count); end
    cycle(1'b1, 16'h3333, 16'h0002, 1'b0, 1'b0, 1'b1);
    checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_full: got %b want 0", obs_in_ready); end
    checks++; if (obs_pcwrite !== 1'b0) begin errors++; $display("FAIL fill_pcwrite_full: got %b want 0", obs_pcwrite); end
    checks++; if (out_ir !== 16'h1111) begin errors++; $display("FAIL fill_head1: got %h want 1111", out_ir); end
    cycle(1'b1, 16'h3333, 16'h0002, 1'b1, 1'b0, 1'b1);
    checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_popcycle: got %b want 0", obs_in_ready); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL fill_count_after_pop: got %0d want 1", count); end
    checks++; if (out_ir !== 16'h2222) begin errors++; $display("FAIL fill_head2: got %h want 2222", out_ir); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready_reopen: got %b want 1", in_ready); end
    cycle(1'b1, 16'h3333, 16'h0002, 1'b1, 1'b0, 1'b1);
    checks++; if (out_ir !== 16'h3333) begin errors++; $display("FAIL fill_head3: got %h want 3333", out_ir); end
`else
    cycle(1'b1, 16'h2222, 16'h0001, 1'b0, 1'b0, 1'b1);
    checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_full: got %b want 0", obs_in_ready); end
    checks++; if (obs_pcwrite !== 1'b0) begin errors++; $display("FAIL fill_pcwrite_full: got %b want 0", obs_pcwrite); end
    checks++; if (out_ir !== 16'h1111) begin errors++; $display("FAIL fill_head1: got %h want 1111", out_ir); end
    cycle(1'b1, 16'h2222, 16'h0001, 1'b1, 1'b0, 1'b1);
    checks++; if (out_ir !== 16'h2222) begin errors++; $display("FAIL fill_head2: got %h want 2222", out_ir); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL fill_count: got %0d want 1", count); end
`endif
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL fill_drain: got %0d want 0", count); end
  endtask

  task automatic test_stream();
    logic [15:0] ir;
    for (int i = 0; i < 8; i++) begin
      ir = 16'($urandom);
      cycle(1'b1, ir, 16'(i), 1'b1, 1'b0, 1'b1);
      checks++; if (obs_pcwrite !== 1'b1) begin errors++; $display("FAIL stream_pcwrite[%0d]: got %b want 1", i, obs_pcwrite); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count); end
      checks++; if (out_pc !== 16'(i) || out_ir !== ir) begin errors++; $display("FAIL stream_head[%0d]: got %h/%h want %h/%h", i, out_ir, out_pc, ir, 16'(i)); end
    end
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'hC000 + 16'(i), 16'h0080 + 16'(i), 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 2'(DEPTH)) begin errors++; $display("FAIL flush_prefill: got %0d want %0d", count, DEPTH); end
    cycle(1'b1, 16'hBEEF, 16'h0100, 1'b0, 1'b1, 1'b1);
    checks++; if (obs_pcwrite !== 1'b0) begin errors++; $display("FAIL flush_pcwrite: got %b want 0", obs_pcwrite); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    checks++; if (out_ir !== m_ir) begin errors++; $display("FAIL flush_hold_ir: got %h want %h", out_ir, m_ir); end
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 16'h0AAA, 16'h0020, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0BBB, 16'h0021, 1'b1, 1'b0, 1'b1);
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL pushpop_in_ready: got %b want 1", obs_in_ready); end
    checks++; if (obs_pcwrite !== 1'b1) begin errors++; $display("FAIL pushpop_pcwrite: got %b want 1", obs_pcwrite); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL pushpop_count: got %0d want 1", count); end
    checks++; if (out_ir !== 16'h0BBB || out_pc !== 16'h0021) begin errors++; $display("FAIL pushpop_head: got %h/%h want 0bbb/0021", out_ir, out_pc); end
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic v = 1'b0, ordy, fl, rs = 1'b1, hold;
    logic [15:0] ir = 16'h0, pc = 16'h0;
    for (int n = 0; n < 400; n++) begin
      hold = v && !exp_in_ready && rs && !fl;
      if (!hold) begin
        v  = ($urandom_range(0, 3) != 0);
        ir = 16'($urandom);
        pc = 16'($urandom);
      end
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 11) == 0);
      rs   = ($urandom_range(0, 49) != 0);
      cycle(v, ir, pc, ordy, fl, rs);
      checks++; if (obs_pcwrite !== exp_pcwrite) begin errors++; $display("FAIL rand_pcwrite[%0d]: got %b want %b", n, obs_pcwrite, exp_pcwrite); end
      checks++; if (obs_in_ready !== exp_in_ready) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, obs_in_ready, exp_in_ready); end
      checks++; if (count !== m_count()) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, count, m_count()); end
      checks++; if (out_valid !== (q_ir.size() != 0)) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", n, out_valid, q_ir.size() != 0); end
      checks++; if (out_ir !== m_ir) begin errors++; $display("FAIL rand_out_ir[%0d]: got %h want %h", n, out_ir, m_ir); end
      checks++; if (out_pc !== m_pc) begin errors++; $display("FAIL rand_out_pc[%0d]: got %h want %h", n, out_pc, m_pc); end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_flush();
    test_push_pop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Pipeline buffer between the fetch stage and the decode stage of the 16-bit processor. It captures each fetched instruction word together with the PC it was fetched from, holds it until decode accepts it, and drives `pcwrite` back to fetch so the PC advances only when an instruction is actually accepted. A synchronous flush discards buffered instructions after a taken branch or jump.

## Interface
Parameters:
- `WIDTH`, 16: instruction and PC width in bits.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low: sampled only on the rising edge of `clk`, and `rst == 0` resets the block.
- `in_ir`  in  WIDTH  instruction word from fetch.
- `in_pc`  in  WIDTH  PC of `in_ir` (fetch `currpc`).
- `in_valid`  in  1  fetch presents a valid instruction.
- `in_ready`  out  1  buffer can accept an instruction this cycle.
- `pcwrite`  out  1  `in_valid & in_ready & ~flush`; tells fetch to advance its PC.
- `out_ir`  out  WIDTH  head instruction to decode.
- `out_pc`  out  WIDTH  PC of the head instruction.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  decode consumes the head entry this cycle.
- `flush`  in  1  discard all entries and any input presented this cycle.
- `count`  out  2  current occupancy (0–2).

## Operation
- Push condition: `in_valid & in_ready & ~flush`.
- Pop condition: `out_valid & out_ready & ~flush`.
- Storage is an in-order queue of {ir, pc} pairs. Depth is 2 with `IFID_SKID_EN` and 1 without it.
- `out_ir` and `out_pc` always show the head entry. There is no combinational input-to-output bypass.
- Push and pop in the same cycle: the head is removed and the new entry is appended, so `count` is unchanged.
- Flush has priority over everything else. On the next edge `count` becomes 0, and the input offered in the flush cycle is dropped (`pcwrite = 0`).
- While `out_valid = 0`, `out_ir` and `out_pc` hold their last values. Decode must qualify them with `out_valid`.
- Reset (`rst == 0` at an edge): `count = 0`, `out_valid = 0`, `out_ir = 16'h0000`, `out_pc = 16'h0000`, `in_ready = 1`, `pcwrite = 0`.
  - Reset asserted mid-operation discards all entries regardless of `in_valid`, `out_ready` or `flush`.
  - `pcwrite` is forced to 0 during any cycle with `rst == 0`.

## Timing
- Latency: an entry pushed at edge N is visible on `out_*` with `out_valid = 1` in the cycle after edge N.
- Throughput: 1 instruction per cycle while `out_ready` stays high.
- `out_valid` is a registered output: `count != 0`.
- `in_ready` behaviour:
  - With `IFID_SKID_EN`, `in_ready = (count < 2)`. It is registered and has no combinational path from `out_ready`.
  - Without `IFID_SKID_EN`, `in_ready = (count == 0) | out_ready`. This is a combinational path from `out_ready`.
- Full with skid (`count == 2`): `in_ready = 0`. A pop that cycle gives `count = 1` at the next edge, and `in_ready = 1` the following cycle.
- Empty (`count == 0`): `out_ready` is ignored and no pop occurs.
- Handshake rule: fetch must hold `in_ir`, `in_pc` and `in_valid` stable while `in_valid & ~in_ready`.

## Configuration
- Macro: `IFID_SKID_EN`.
- When defined:
  - 2-entry skid queue; `in_ready` is registered.
  - `count` ranges over 0–2.
- When undefined:
  - Single pipeline register; `in_ready = (count == 0) | out_ready`.
  - `count` ranges over 0–1; bit 1 is tied to 0.
  - Reset, flush and push/pop rules are otherwise identical.

## Test plan
- Reset: hold `rst = 0` for 2 edges while `in_valid = 1`, `in_ir = 16'h1234` → `out_valid = 0`, `count = 0`, `out_ir = 16'h0000`, `pcwrite = 0`, `in_ready = 1`.
- Single transfer: push {16'hA005, 16'h0010} with `out_ready = 0` → next cycle `out_valid = 1`, `out_ir = 16'hA005`, `out_pc = 16'h0010`, `count = 1`. Assert `out_ready` for 1 cycle → `count = 0`.
- Fill (skid): push {16'h1111, 16'h0000} then {16'h2222, 16'h0001} with `out_ready = 0` → `count = 2`, `in_ready = 0`, `pcwrite = 0` while `in_valid = 1`. Then pop twice → `out_ir` shows 16'h1111 then 16'h2222.
- Streaming: 8 back-to-back pushes with PCs 0–7 and `out_ready = 1` → 8 pops in order, `count` stays at 1, one instruction per cycle.
- Flush: with `count = 2`, assert `flush` together with `in_valid = 1` → `pcwrite = 0`, and at the next edge `count = 0`, `out_valid = 0`.
- Non-skid build: with `count = 1`, `out_ready = 1` and `in_valid = 1` → `in_ready = 1`, `pcwrite = 1`, and `count` stays at 1 with the new head.
